pc_fetch_unit: RTL

//  Program-counter/fetch stage directly upstream of instruction memory: holds the PC,

---
 rtl/pc_fetch_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter / fetch stage with stall, halt, fault and fetch counter
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 halt_req,
    input  logic                 branch_taken,
    input  logic [15:0]          branch_imm,
    input  logic                 jump,
    input  logic [25:0]          jump_index,
    input  logic                 jump_reg,
    input  logic [31:0]          reg_target,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 fetch_valid,
    output logic                 halted,
    output logic                 fault,
    output logic [31:0]          fault_addr,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] seq_next;
    logic        target_misaligned;

    assign pc_plus4          = pc + 32'd4;
    assign branch_target     = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jump_target       = {pc_plus4[31:28], jump_index, 2'b00};
    assign target_misaligned = (reg_target[1:0] != 2'b00);

    // Non-register redirects; jr is handled separately because it may fault.
    always_comb begin
        seq_next = pc_plus4;
        if (jump) begin
            seq_next = jump_target;
        end else if (branch_taken) begin
            seq_next = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_VECTOR;
            fault_addr  <= 32'h0000_0000;
            fetch_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state <= HALTED;
                    end else if (!stall) begin
                        if (jump_reg) begin
                            if (target_misaligned) begin
                                state      <= FAULT;
                                fault_addr <= reg_target;
                            end else begin
                                pc          <= reg_target;
                                fetch_count <= fetch_count + CNT_WIDTH'(1);
                            end
                        end else begin
                            pc          <= seq_next;
                            fetch_count <= fetch_count + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    // HALTED and FAULT hold everything until reset.
                end
            endcase
        end
    end

    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALTED);
    assign fault       = (state == FAULT);

endmodule
